// File: rtl/seq_bit_frontend_if.sv
// Output bus of the serial-bit front end toward the sequence detector and debug display.
// Latency: none, plain wires.
// Backpressure: none, the consumer must take every bit_valid pulse.
// Ports: bit_valid/bit_data (bit strobe + data), hist/bit_cnt (debug history and count),
//        glitch_seen (sticky debounce reject flag).
interface seq_bit_frontend_if;
    logic       bit_valid;
    logic       bit_data;
    logic [7:0] hist;
    logic [7:0] bit_cnt;
    logic       glitch_seen;

    // Front end drives the bus.
    modport master (
        output bit_valid,
        output bit_data,
        output hist,
        output bit_cnt,
        output glitch_seen
    );

    // Detector / display side observes it.
    modport slave (
        input bit_valid,
        input bit_data,
        input hist,
        input bit_cnt,
        input glitch_seen
    );
endinterface

// File: rtl/seq_bit_frontend.sv
// Synchronize din/strobe pins, debounce strobe, emit one bit_valid per accepted strobe rise.
// Latency: strobe pin rise to bit_valid is 1+DB_CYCLES edges after sync, 2 edges without debounce.
// Backpressure: none; with ena low accepted edges are dropped, never queued.
// Optional feature macro: SEQ_FE_DEBOUNCE_EN (builds the debouncer; otherwise strobe is only
// registered once after synchronization and glitch_seen is tied low).
// Ports: clk, rst (sync, active-high), ena, din_raw, strb_raw, clr; out_if carries
//        bit_valid, bit_data, hist[7:0], bit_cnt[7:0], glitch_seen.
module seq_bit_frontend #(
    parameter int DB_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       din_raw,
    input  logic                       strb_raw,
    input  logic                       clr,
    seq_bit_frontend_if.master         out_if
);

    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_param
        $error("seq_bit_frontend: DB_CYCLES out of range 1..255");
    end

    // Two-flop synchronizers for both asynchronous pins.
    logic din_m;
    logic din_s;
    logic strb_m;
    logic strb_s;

    // Stable strobe level and its next value; an accepted edge is a 0->1 update.
    logic strb_db;
    logic strb_db_nxt;
    logic glitch_q;

    logic       bit_valid_q;
    logic       bit_data_q;
    logic [7:0] hist_q;
    logic [7:0] bit_cnt_q;
    logic       accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_m   <= 1'b0;
            din_s   <= 1'b0;
            strb_m  <= 1'b0;
            strb_s  <= 1'b0;
            strb_db <= 1'b0;
        end else begin
            din_m   <= din_raw;
            din_s   <= din_m;
            strb_m  <= strb_raw;
            strb_s  <= strb_m;
            strb_db <= strb_db_nxt;
        end
    end

`ifdef SEQ_FE_DEBOUNCE_EN
    localparam int                CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]     DB_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_cnt_nxt;
    logic          glitch_det;

    // A level change must persist DB_CYCLES synchronized cycles; returning to the
    // stable level mid-count is a rejected glitch. The counter resets on acceptance
    // so it never reaches DB_CYCLES and cannot wrap.
    always_comb begin
        strb_db_nxt = strb_db;
        db_cnt_nxt  = db_cnt;
        glitch_det  = 1'b0;
        if (strb_s == strb_db) begin
            db_cnt_nxt = '0;
            glitch_det = (db_cnt != '0);
        end else if (db_cnt == DB_LAST) begin
            strb_db_nxt = strb_s;
            db_cnt_nxt  = '0;
        end else begin
            db_cnt_nxt = db_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            glitch_q <= 1'b0;
        end else begin
            db_cnt <= db_cnt_nxt;
            if (clr) begin
                glitch_q <= 1'b0;
            end else if (glitch_det) begin
                glitch_q <= 1'b1;
            end
        end
    end
`else
    // Without the debouncer the strobe is simply registered once more.
    always_comb begin
        strb_db_nxt = strb_s;
    end

    assign glitch_q = 1'b0;
`endif

    // Edge is judged on the value being loaded this cycle, so bit_valid lands on the
    // same clock edge as the strb_db rise.
    assign accept = ena & strb_db_nxt & ~strb_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            hist_q      <= 8'h00;
            bit_cnt_q   <= 8'h00;
        end else begin
            bit_valid_q <= accept;
            if (accept) begin
                bit_data_q <= din_s;
            end
            // clr takes priority over a coincident bit for the debug state only;
            // the pulse itself still goes out.
            if (clr) begin
                hist_q    <= 8'h00;
                bit_cnt_q <= 8'h00;
            end else if (accept) begin
                hist_q    <= {hist_q[6:0], din_s};
                bit_cnt_q <= bit_cnt_q + 8'd1;
            end
        end
    end

    assign out_if.bit_valid   = bit_valid_q;
    assign out_if.bit_data    = bit_data_q;
    assign out_if.hist        = hist_q;
    assign out_if.bit_cnt     = bit_cnt_q;
    assign out_if.glitch_seen = glitch_q;

endmodule

// File: tb/tb_seq_bit_frontend.sv
module tb_seq_bit_frontend;

    localparam int DB = 4;
`ifdef SEQ_FE_DEBOUNCE_EN
    localparam int   LAT  = DB + 1;
    localparam logic DBEN = 1'b1;
`else
    localparam int   LAT  = 2;
    localparam logic DBEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic din_raw = 1'b0;
    logic strb_raw = 1'b0;
    logic clr = 1'b0;

    seq_bit_frontend_if bus ();

    seq_bit_frontend #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .din_raw  (din_raw),
        .strb_raw (strb_raw),
        .clr      (clr),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    // Edge number of the most recent rising clock edge.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         edge_no;
        logic       d;
        logic [7:0] h;
        logic [7:0] c;
    } exp_t;

    exp_t       q[$];
    logic [7:0] hist_m = 8'h00;
    logic [7:0] cnt_m  = 8'h00;
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the accepted-bit side effects; only bits accepted with ena high produce output.
    task automatic expect_bit(input int edge_no, input logic d);
        if (ena) begin
            hist_m = {hist_m[6:0], d};
            cnt_m  = cnt_m + 8'd1;
            q.push_back('{edge_no, d, hist_m, cnt_m});
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.bit_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk  = n_chk + 1;
                n_fail = n_fail + 1;
                $display("FAIL unexpected_pulse: got bit_valid=1 expected none (edge %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_edge", cyc, e.edge_no);
                check("bit_data", {31'd0, bus.bit_data}, {31'd0, e.d});
                check("hist_at_pulse", {24'd0, bus.hist}, {24'd0, e.h});
                check("cnt_at_pulse", {24'd0, bus.bit_cnt}, {24'd0, e.c});
            end
        end
    end

    task automatic send_bit(input logic d, input int hi, input int lo);
        @(negedge clk);
        din_raw = d;
        repeat (4) @(negedge clk);
        strb_raw = 1'b1;
        expect_bit(cyc + 1 + LAT, d);
        repeat (hi) @(negedge clk);
        strb_raw = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        hist_m = 8'h00;
        cnt_m  = 8'h00;
    endtask

    int   k;
    logic [7:0] bits4;

    initial begin
        // Reset with random pins.
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            din_raw  = 1'($urandom);
            strb_raw = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        din_raw = 1'b0;
        strb_raw = 1'b0;
        @(negedge clk);
        check("rst_bit_valid", {31'd0, bus.bit_valid}, 0);
        check("rst_bit_data", {31'd0, bus.bit_data}, 0);
        check("rst_hist", {24'd0, bus.hist}, 0);
        check("rst_bit_cnt", {24'd0, bus.bit_cnt}, 0);
        check("rst_glitch", {31'd0, bus.glitch_seen}, 0);

        // Clean bits 1,0,1,1.
        bits4 = 8'b0000_1011;
        for (int i = 3; i >= 0; i--) send_bit(bits4[i], 20, 20);
        check("clean_hist", {24'd0, bus.hist}, 32'h0B);
        check("clean_cnt", {24'd0, bus.bit_cnt}, 4);
        check("clean_glitch", {31'd0, bus.glitch_seen}, 0);

        // Bounce: 1,0,1 then held high.
        @(negedge clk);
        din_raw = 1'b1;
        repeat (4) @(negedge clk);
        strb_raw = 1'b1;
        k = cyc + 1;
`ifdef SEQ_FE_DEBOUNCE_EN
        expect_bit(k + 2 + LAT, 1'b1);
`else
        expect_bit(k + LAT, 1'b1);
        expect_bit(k + 2 + LAT, 1'b1);
`endif
        @(negedge clk);
        strb_raw = 1'b0;
        @(negedge clk);
        strb_raw = 1'b1;
        repeat (10) @(negedge clk);
        strb_raw = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_glitch", {31'd0, bus.glitch_seen}, {31'd0, DBEN});

        // Short 2-cycle pulse.
        do_clr();
        check("clr_glitch", {31'd0, bus.glitch_seen}, 0);
        @(negedge clk);
        din_raw = 1'b0;
        repeat (4) @(negedge clk);
        strb_raw = 1'b1;
`ifndef SEQ_FE_DEBOUNCE_EN
        expect_bit(cyc + 1 + LAT, 1'b0);
`endif
        repeat (2) @(negedge clk);
        strb_raw = 1'b0;
        repeat (20) @(negedge clk);
        check("short_glitch", {31'd0, bus.glitch_seen}, {31'd0, DBEN});
        do_clr();
        check("glitch_after_clr", {31'd0, bus.glitch_seen}, 0);
        check("hist_after_clr", {24'd0, bus.hist}, 0);

        // Counter wrap over 257 bits.
        for (int i = 0; i < 257; i++) send_bit(1'(i % 3 == 0), 6, 6);
        check("wrap_cnt", {24'd0, bus.bit_cnt}, 1);
        check("wrap_hist", {24'd0, bus.hist}, {24'd0, hist_m});

        // Disabled strobe is dropped.
        ena = 1'b0;
        send_bit(1'b0, 6, 6);
        check("ena_off_cnt", {24'd0, bus.bit_cnt}, 1);
        check("ena_off_hist", {24'd0, bus.hist}, {24'd0, hist_m});
        ena = 1'b1;

        // Reset while a strobe is being debounced.
        @(negedge clk);
        din_raw = 1'b1;
        repeat (4) @(negedge clk);
        strb_raw = 1'b1;
`ifdef SEQ_FE_DEBOUNCE_EN
        repeat (4) @(negedge clk);
`else
        repeat (1) @(negedge clk);
`endif
        rst = 1'b1;
        strb_raw = 1'b0;
        hist_m = 8'h00;
        cnt_m  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_cnt", {24'd0, bus.bit_cnt}, 0);
        check("midrst_hist", {24'd0, bus.hist}, 0);
        send_bit(1'b1, 20, 20);
        check("post_rst_cnt", {24'd0, bus.bit_cnt}, 1);
        check("post_rst_hist", {24'd0, bus.hist}, 1);

        repeat (10) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
